// File: rtl/snn_inference_scheduler.sv
// Per-sample sequencer for the integrate-and-fire network. It rate-codes latched intensities
// into input spikes, counts output spikes, and reports the argmax class over valid/ready.
module snn_inference_scheduler #(
   parameter int unsigned NUM_INPUTS      = 4,
   parameter int unsigned NUM_OUTPUTS     = 2,
   parameter int unsigned INTENSITY_WIDTH = 8,
   parameter int unsigned NUM_STEPS       = 16,
   parameter int unsigned CLEAR_CYCLES    = 2,
   parameter int unsigned DRAIN_CYCLES    = 4,
   parameter int unsigned COUNT_WIDTH     = 8,
   localparam int unsigned CLASS_WIDTH    = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [NUM_INPUTS*INTENSITY_WIDTH-1:0] in_intensity,
   output logic                                  net_rst,
   output logic [NUM_INPUTS-1:0]                 net_spike_in,
   input  logic [NUM_OUTPUTS-1:0]                net_spike_out,
   output logic                                  busy,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [CLASS_WIDTH-1:0]                out_class,
   output logic [COUNT_WIDTH-1:0]                out_max_count,
   output logic                                  out_none
);

   localparam int unsigned W = INTENSITY_WIDTH;
   localparam int unsigned MAX_A = (CLEAR_CYCLES > NUM_STEPS) ? CLEAR_CYCLES : NUM_STEPS;
   localparam int unsigned MAX_PHASE = (DRAIN_CYCLES > MAX_A) ? DRAIN_CYCLES : MAX_A;
   localparam int unsigned PHASE_WIDTH = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
   localparam logic [PHASE_WIDTH-1:0] CLEAR_LAST = PHASE_WIDTH'(CLEAR_CYCLES - 1);
   localparam logic [PHASE_WIDTH-1:0] RUN_LAST = PHASE_WIDTH'(NUM_STEPS - 1);
   localparam logic [PHASE_WIDTH-1:0] DRAIN_LAST =
      PHASE_WIDTH'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [CLASS_WIDTH-1:0] SCAN_LAST = CLASS_WIDTH'(NUM_OUTPUTS - 1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StDrain,
      StArgmax,
      StDone
   } state_e;

   state_e                          r_state;
   state_e                          w_state_next;
   logic [PHASE_WIDTH-1:0]          r_phase;
   logic [CLASS_WIDTH-1:0]          r_scan;
   logic [NUM_INPUTS*W-1:0]         r_intensity;
   logic [W-1:0]                    r_acc [NUM_INPUTS];
   logic [COUNT_WIDTH-1:0]          r_count [NUM_OUTPUTS];
   logic [CLASS_WIDTH-1:0]          r_best_idx;
   logic [COUNT_WIDTH-1:0]          r_best_cnt;
   logic [CLASS_WIDTH-1:0]          r_out_class;
   logic [COUNT_WIDTH-1:0]          r_out_max;
   logic                            r_out_none;

   logic [W:0]                      w_sum [NUM_INPUTS];
   logic                            w_accept;
   logic [COUNT_WIDTH-1:0]          w_scan_cnt;
   logic                            w_take;
   logic [CLASS_WIDTH-1:0]          w_best_idx_next;
   logic [COUNT_WIDTH-1:0]          w_best_cnt_next;

   assign in_ready      = (r_state == StIdle) && !rst;
   assign w_accept      = in_valid && in_ready;
   assign net_rst       = rst || (r_state == StClear);
   assign busy          = (r_state != StIdle);
   assign out_valid     = (r_state == StDone);
   assign out_class     = r_out_class;
   assign out_max_count = r_out_max;
   assign out_none      = r_out_none;

   // The carry out of each phase accumulator is the spike for that step.
   always_comb begin
      net_spike_in = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         w_sum[i]        = {1'b0, r_acc[i]} + {1'b0, r_intensity[i*W +: W]};
         net_spike_in[i] = (r_state == StRun) && w_sum[i][W];
      end
   end

   // Index 0 is always taken first; later indices only win on a strictly greater count.
   always_comb begin
      w_scan_cnt      = r_count[r_scan];
      w_take          = (r_scan == '0) || (w_scan_cnt > r_best_cnt);
      w_best_idx_next = w_take ? r_scan : r_best_idx;
      w_best_cnt_next = w_take ? w_scan_cnt : r_best_cnt;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) w_state_next = StClear;
         end
         StClear: begin
            if (r_phase == CLEAR_LAST) w_state_next = StRun;
         end
         StRun: begin
            if (r_phase == RUN_LAST) begin
               if (DRAIN_CYCLES > 0) w_state_next = StDrain;
               else                  w_state_next = StArgmax;
            end
         end
         StDrain: begin
            if (r_phase == DRAIN_LAST) w_state_next = StArgmax;
         end
         StArgmax: begin
            if (r_scan == SCAN_LAST) w_state_next = StDone;
         end
         StDone: begin
            if (out_ready) w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_phase     <= '0;
         r_scan      <= '0;
         r_intensity <= '0;
         r_best_idx  <= '0;
         r_best_cnt  <= '0;
         r_out_class <= '0;
         r_out_max   <= '0;
         r_out_none  <= 1'b0;
         for (int i = 0; i < NUM_INPUTS; i++) r_acc[i] <= '0;
         for (int j = 0; j < NUM_OUTPUTS; j++) r_count[j] <= '0;
      end else begin
         r_state <= w_state_next;
         r_phase <= (w_state_next != r_state) ? '0 : r_phase + 1'b1;

         if (w_accept) begin
            r_intensity <= in_intensity;
            for (int i = 0; i < NUM_INPUTS; i++) r_acc[i] <= '0;
            for (int j = 0; j < NUM_OUTPUTS; j++) r_count[j] <= '0;
         end

         if (r_state == StRun) begin
            for (int i = 0; i < NUM_INPUTS; i++) r_acc[i] <= w_sum[i][W-1:0];
         end

         if ((r_state == StRun) || (r_state == StDrain)) begin
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
               if (net_spike_out[j] && (r_count[j] != COUNT_MAX)) begin
                  r_count[j] <= r_count[j] + 1'b1;
               end
            end
         end

         if (r_state == StArgmax) begin
            r_scan     <= r_scan + 1'b1;
            r_best_idx <= w_best_idx_next;
            r_best_cnt <= w_best_cnt_next;
            if (r_scan == SCAN_LAST) begin
               r_out_class <= w_best_idx_next;
               r_out_max   <= w_best_cnt_next;
               r_out_none  <= (w_best_cnt_next == '0);
            end
         end else begin
            r_scan <= '0;
         end
      end
   end

endmodule

// File: tb/tb_snn_inference_scheduler.sv
// Bench for snn_inference_scheduler: two instances (default and 4-bit counters) share stimulus
// and are checked against a closed-form rate-coding and spike-count reference model.
module tb_snn_inference_scheduler;

   localparam int unsigned NI    = 4;
   localparam int unsigned NO    = 2;
   localparam int unsigned W     = 8;
   localparam int unsigned STEPS = 16;
   localparam int unsigned CLR   = 2;
   localparam int unsigned DRN   = 4;
   localparam int unsigned CYC   = STEPS + DRN;
   localparam int unsigned LAT   = CLR + STEPS + DRN + NO + 1;
   localparam int unsigned SAT_A = 255;
   localparam int unsigned SAT_B = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            out_ready;
   logic [NI*W-1:0] in_intensity;
   logic [NO-1:0]   net_spike_out;

   logic            in_ready_a, net_rst_a, busy_a, out_valid_a, out_none_a;
   logic [NI-1:0]   spike_in_a;
   logic [0:0]      out_class_a;
   logic [7:0]      out_max_a;
   logic            in_ready_b, net_rst_b, busy_b, out_valid_b, out_none_b;
   logic [NI-1:0]   spike_in_b;
   logic [0:0]      out_class_b;
   logic [3:0]      out_max_b;

   int n_cmp = 0;
   int n_err = 0;
   logic [NO-1:0] pat [CYC];
   int prev_cls_a, prev_max_a, prev_none_a, prev_cls_b, prev_max_b, prev_none_b;

   always #5 clk = ~clk;

   snn_inference_scheduler u_dut_a (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready_a),
      .in_intensity  (in_intensity),
      .net_rst       (net_rst_a),
      .net_spike_in  (spike_in_a),
      .net_spike_out (net_spike_out),
      .busy          (busy_a),
      .out_valid     (out_valid_a),
      .out_ready     (out_ready),
      .out_class     (out_class_a),
      .out_max_count (out_max_a),
      .out_none      (out_none_a)
   );

   snn_inference_scheduler #(.COUNT_WIDTH(4)) u_dut_b (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready_b),
      .in_intensity  (in_intensity),
      .net_rst       (net_rst_b),
      .net_spike_in  (spike_in_b),
      .net_spike_out (net_spike_out),
      .busy          (busy_b),
      .out_valid     (out_valid_b),
      .out_ready     (out_ready),
      .out_class     (out_class_b),
      .out_max_count (out_max_b),
      .out_none      (out_none_b)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Spike on step t iff floor(t*I/2^W) advances from step t-1.
   function automatic logic spike_at(input int unsigned inten, input int unsigned t);
      return ((t * inten) >> W) != (((t - 1) * inten) >> W);
   endfunction

   task automatic rand_pattern();
      int unsigned d;
      d = $urandom_range(0, 100);
      for (int c = 0; c < CYC; c++)
         for (int j = 0; j < NO; j++) pat[c][j] = ($urandom_range(0, 99) < d);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int c = 0; c < n; c++) begin
         net_spike_out = NO'($urandom);
         step();
         chk("idle_busy", busy_a, 0);
         chk("idle_in_ready", in_ready_a, 1);
         chk("idle_out_valid", out_valid_a, 0);
      end
   endtask

   task automatic run_sample(input logic [NI*W-1:0] inten, input int hold, input bit keep_valid);
      int obs_tot [NI];
      int cnt_a [NO];
      int cnt_b [NO];
      int ecls_a, ecls_b;
      for (int j = 0; j < NO; j++) begin
         cnt_a[j] = 0;
         for (int c = 0; c < CYC; c++) cnt_a[j] += int'(pat[c][j]);
         cnt_b[j] = (cnt_a[j] > SAT_B) ? SAT_B : cnt_a[j];
         if (cnt_a[j] > SAT_A) cnt_a[j] = SAT_A;
      end
      ecls_a = 0;
      ecls_b = 0;
      for (int j = 1; j < NO; j++) begin
         if (cnt_a[j] > cnt_a[ecls_a]) ecls_a = j;
         if (cnt_b[j] > cnt_b[ecls_b]) ecls_b = j;
      end
      for (int i = 0; i < NI; i++) obs_tot[i] = 0;

      in_valid     = 1'b1;
      in_intensity = inten;
      for (int k = 1; k <= LAT; k++) begin
         step();
         chk("busy", busy_a, 1);
         chk("in_ready", in_ready_a, 0);
         chk("net_rst", net_rst_a, 32'(k <= CLR));
         chk("out_valid_a", out_valid_a, 32'(k == LAT));
         chk("out_valid_b", out_valid_b, 32'(k == LAT));
         if (k > CLR && k <= CLR + STEPS) begin
            for (int i = 0; i < NI; i++) begin
               chk("spike_in", spike_in_a[i], spike_at(inten[i*W +: W], k - CLR));
               obs_tot[i] += int'(spike_in_a[i]);
            end
         end else begin
            chk("spike_in_quiet", spike_in_a, 0);
         end
         if (k == LAT - 1) begin
            chk("held_class_a", out_class_a, prev_cls_a);
            chk("held_max_a", out_max_a, prev_max_a);
            chk("held_none_b", out_none_b, prev_none_b);
            chk("held_max_b", out_max_b, prev_max_b);
         end
         in_valid      = keep_valid;
         in_intensity  = $urandom;
         net_spike_out = (k > CLR && k <= CLR + CYC) ? pat[k-CLR-1] : NO'($urandom);
      end

      for (int i = 0; i < NI; i++) chk("spike_total", obs_tot[i], (STEPS * inten[i*W +: W]) >> W);
      chk("class_a", out_class_a, ecls_a);
      chk("max_a", out_max_a, cnt_a[ecls_a]);
      chk("none_a", out_none_a, 32'(cnt_a[ecls_a] == 0));
      chk("class_b", out_class_b, ecls_b);
      chk("max_b", out_max_b, cnt_b[ecls_b]);
      chk("none_b", out_none_b, 32'(cnt_b[ecls_b] == 0));

      for (int h = 0; h < hold; h++) begin
         net_spike_out = NO'($urandom);
         step();
         chk("hold_valid", out_valid_a, 1);
         chk("hold_in_ready", in_ready_a, 0);
         chk("hold_class", out_class_a, ecls_a);
         chk("hold_max", out_max_a, cnt_a[ecls_a]);
         chk("hold_max_b", out_max_b, cnt_b[ecls_b]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post_valid", out_valid_a, 0);
      chk("post_busy", busy_a, 0);
      chk("post_in_ready", in_ready_a, 1);
      chk("post_class", out_class_a, ecls_a);
      chk("post_max", out_max_a, cnt_a[ecls_a]);
      prev_cls_a  = ecls_a;
      prev_max_a  = cnt_a[ecls_a];
      prev_none_a = int'(cnt_a[ecls_a] == 0);
      prev_cls_b  = ecls_b;
      prev_max_b  = cnt_b[ecls_b];
      prev_none_b = int'(cnt_b[ecls_b] == 0);
   endtask

   task automatic mid_reset();
      rand_pattern();
      in_valid     = 1'b1;
      in_intensity = $urandom;
      for (int k = 1; k <= CLR + 7; k++) begin
         step();
         in_valid      = 1'b0;
         net_spike_out = NO'($urandom);
      end
      chk("mid_busy", busy_a, 1);
      rst = 1'b1;
      #1;
      chk("mid_net_rst", net_rst_a, 1);
      step();
      chk("mid_spike_in", spike_in_a, 0);
      chk("mid_busy_after", busy_a, 0);
      chk("mid_out_valid", out_valid_a, 0);
      chk("mid_class", out_class_a, 0);
      chk("mid_max", out_max_a, 0);
      rst = 1'b0;
      prev_cls_a = 0; prev_max_a = 0; prev_none_a = 0;
      prev_cls_b = 0; prev_max_b = 0; prev_none_b = 0;
      step();
      chk("mid_in_ready", in_ready_a, 1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_intensity = '0; net_spike_out = '0;
      prev_cls_a = 0; prev_max_a = 0; prev_none_a = 0;
      prev_cls_b = 0; prev_max_b = 0; prev_none_b = 0;

      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_net_rst", net_rst_a, 1);
         chk("rst_out_valid", out_valid_a, 0);
         chk("rst_spike_in", spike_in_a, 0);
         chk("rst_busy", busy_a, 0);
         chk("rst_class", out_class_a, 0);
         chk("rst_max", out_max_a, 0);
         chk("rst_none", out_none_a, 0);
      end
      rst = 1'b0;
      step();
      chk("rel_in_ready", in_ready_a, 1);
      chk("rel_net_rst", net_rst_a, 0);

      // Rate coding with no output spikes: intensities 0, 64, 128, 255.
      for (int c = 0; c < CYC; c++) pat[c] = '0;
      run_sample({8'd255, 8'd128, 8'd64, 8'd0}, 0, 1'b0);
      chk("rate_none", out_none_a, 1);
      idle(2);

      // Output 0 gets 5 spikes, output 1 gets 9 with two in DRAIN.
      for (int c = 0; c < CYC; c++) begin
         pat[c][0] = (c < 5);
         pat[c][1] = (c >= 3 && c <= 9) || c == 16 || c == 17;
      end
      run_sample($urandom, 0, 1'b0);
      chk("five_nine_class", out_class_a, 1);
      chk("five_nine_max", out_max_a, 9);
      idle(1);

      // Equal counts resolve to the lowest index.
      for (int c = 0; c < CYC; c++) begin
         pat[c][0] = (c < 7);
         pat[c][1] = (c >= 10 && c <= 16);
      end
      run_sample($urandom, 0, 1'b0);
      chk("tie_class", out_class_a, 0);
      idle(1);

      // Output 1 every counted cycle; back-pressure then back-to-back accept.
      for (int c = 0; c < CYC; c++) pat[c] = 2'b10;
      run_sample($urandom, 10, 1'b1);
      chk("sat_max_b", out_max_b, 15);
      rand_pattern();
      run_sample($urandom, 0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         bit kv;
         kv = 1'($urandom);
         rand_pattern();
         run_sample($urandom, $urandom_range(0, 3), kv);
         if (!kv) idle($urandom_range(0, 2));
      end

      mid_reset();
      rand_pattern();
      run_sample($urandom, 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
